// File: rtl/button_conditioner.sv
// Debounces four push buttons and turns presses (plus left/right auto-repeat)
// into one-cycle event pulses aligned to the consumer's game tick.
module button_conditioner #(
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       throw_raw,
  input  logic       restart_raw,
  output logic       left,
  output logic       right,
  output logic       throw,
  output logic       restart,
  output logic [3:0] held
);

  localparam logic [15:0] DEB_LAST    = 16'(DEB_CYCLES - 1);
  localparam logic [7:0]  DELAY       = 8'(REPEAT_DELAY);
  localparam logic [7:0]  DELAY_LAST  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]  PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

  logic [3:0]  raw, sync1, sync2, stable, stable_d;
  logic [3:0]  press, event_now, pend, want, emit;
  logic [1:0]  rep_now;
  logic [15:0] deb_cnt [4];
  logic [7:0]  hold_cnt [2];
  logic [7:0]  phase [2];

  assign raw   = {restart_raw, throw_raw, right_raw, left_raw};
  assign press = stable & ~stable_d;
  assign held  = stable;

  // Synchronize, then flip the stable level only after DEB_CYCLES of disagreement
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // The phase counter keeps repeats going after the hold count saturates
  always_comb begin
    rep_now = '0;
    for (int i = 0; i < 2; i++) begin
      rep_now[i] = tick & stable[i] & ~press[i] &
                   ((hold_cnt[i] == DELAY_LAST) |
                    ((hold_cnt[i] >= DELAY) & (phase[i] == PERIOD_LAST)));
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        hold_cnt[i] <= '0;
        phase[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (press[i] | ~stable[i]) begin
          hold_cnt[i] <= '0;
          phase[i]    <= '0;
        end else if (tick) begin
          if (hold_cnt[i] != 8'hFF) hold_cnt[i] <= hold_cnt[i] + 8'd1;
          if (hold_cnt[i] == DELAY_LAST) begin
            phase[i] <= '0;
          end else if (hold_cnt[i] >= DELAY) begin
            phase[i] <= (phase[i] == PERIOD_LAST) ? 8'd0 : phase[i] + 8'd1;
          end
        end
      end
    end
  end

  // Left and right cancel each other when both land on the same tick
  always_comb begin
    event_now = press | {2'b00, rep_now};
    want      = {4{tick}} & (pend | event_now);
    emit      = want;
    if (want[0] & want[1]) emit[1:0] = 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pend    <= '0;
      left    <= 1'b0;
      right   <= 1'b0;
      throw   <= 1'b0;
      restart <= 1'b0;
    end else begin
      pend <= tick ? 4'b0000 : (pend | event_now);
      {restart, throw, right, left} <= emit;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with short debounce and repeat settings.
module tb_button_conditioner;

  logic       CLK;
  logic       reset;
  logic       tick;
  logic       left_raw, right_raw, throw_raw, restart_raw;
  logic       left, right, throw, restart;
  logic [3:0] held;

  int checks = 0;
  int errors = 0;
  int pcLeft, pcRight, pcThrow, pcRestart;

  button_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (3),
    .REPEAT_PERIOD(2)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .tick       (tick),
    .left_raw   (left_raw),
    .right_raw  (right_raw),
    .throw_raw  (throw_raw),
    .restart_raw(restart_raw),
    .left       (left),
    .right      (right),
    .throw      (throw),
    .restart    (restart),
    .held       (held)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n clocks, sampling 1 time unit after each edge and tallying pulses
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      pcLeft    += int'(left);
      pcRight   += int'(right);
      pcThrow   += int'(throw);
      pcRestart += int'(restart);
    end
  endtask

  task automatic doTick();
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
  endtask

  task automatic clearCounts();
    pcLeft = 0; pcRight = 0; pcThrow = 0; pcRestart = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    left_raw = 1'b0; right_raw = 1'b0; throw_raw = 1'b0; restart_raw = 1'b0;
    clearCounts();

    // Reset state, with tick asserted to show reset wins
    applyStimulus(2);
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
    checkOutput("reset_outputs", {28'd0, restart, throw, right, left}, 32'd0);
    checkOutput("reset_held", {28'd0, held}, 32'd0);
    reset = 1'b0;
    applyStimulus(3);

    // Short glitch on left never becomes stable
    $display("[TB] glitch rejection");
    clearCounts();
    left_raw = 1'b1;
    applyStimulus(3);
    left_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      checkOutput("glitch_held", {31'd0, held[0]}, 32'd0);
    end
    doTick();
    applyStimulus(2);
    checkOutput("glitch_left_count", pcLeft, 0);

    // Throw held: stable after 6 clocks, one pulse, no repeats
    $display("[TB] throw hold");
    clearCounts();
    throw_raw = 1'b1;
    applyStimulus(5);
    checkOutput("throw_held_early", {31'd0, held[2]}, 32'd0);
    applyStimulus(1);
    checkOutput("throw_held_on", {31'd0, held[2]}, 32'd1);
    applyStimulus(3);
    checkOutput("throw_before_tick", pcThrow, 0);
    doTick();
    checkOutput("throw_pulse", {31'd0, throw}, 32'd1);
    applyStimulus(1);
    checkOutput("throw_width", {31'd0, throw}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8);
      doTick();
    end
    applyStimulus(1);
    checkOutput("throw_count", pcThrow, 1);
    throw_raw = 1'b0;
    applyStimulus(10);
    doTick();
    applyStimulus(1);
    checkOutput("throw_release_count", pcThrow, 1);
    checkOutput("throw_released", {31'd0, held[2]}, 32'd0);

    // Right held for 12 ticks: press tick then repeats on hold ticks 3,5,7,9,11
    $display("[TB] right auto-repeat");
    clearCounts();
    right_raw = 1'b1;
    applyStimulus(7);
    for (int k = 1; k <= 12; k++) begin
      doTick();
      checkOutput($sformatf("right_tick%0d", k), {31'd0, right},
                  (k == 1 || k == 3 || k == 5 || k == 7 || k == 9 || k == 11) ? 32'd1 : 32'd0);
      applyStimulus(2);
    end
    checkOutput("right_count", pcRight, 6);
    right_raw = 1'b0;
    applyStimulus(10);
    doTick();
    applyStimulus(1);
    checkOutput("right_release_count", pcRight, 6);

    // Left and right in the same window cancel
    $display("[TB] left/right conflict");
    clearCounts();
    left_raw = 1'b1;
    applyStimulus(1);
    right_raw = 1'b1;
    applyStimulus(8);
    doTick();
    checkOutput("conflict_tick1", {30'd0, right, left}, 32'd0);
    applyStimulus(3);
    doTick();
    checkOutput("conflict_tick2", {30'd0, right, left}, 32'd0);
    left_raw = 1'b0; right_raw = 1'b0;
    applyStimulus(10);
    doTick();
    applyStimulus(1);
    checkOutput("conflict_counts", pcLeft + pcRight, 0);

    // Restart pending discarded by reset, which also overrides a tick
    $display("[TB] reset discards pending");
    clearCounts();
    restart_raw = 1'b1;
    applyStimulus(8);
    restart_raw = 1'b0;
    reset = 1'b1; tick = 1'b1;
    applyStimulus(1);
    checkOutput("rst_mid_outputs", {28'd0, restart, throw, right, left}, 32'd0);
    checkOutput("rst_mid_held", {28'd0, held}, 32'd0);
    reset = 1'b0; tick = 1'b0;
    applyStimulus(10);
    doTick();
    checkOutput("rst_after_outputs", {28'd0, restart, throw, right, left}, 32'd0);
    applyStimulus(1);
    checkOutput("rst_restart_count", pcRestart, 0);

    // Button held through reset release is debounced afresh: one event
    $display("[TB] held through reset");
    clearCounts();
    throw_raw = 1'b1;
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(5);
    checkOutput("hold_rst_early", {31'd0, held[2]}, 32'd0);
    applyStimulus(1);
    checkOutput("hold_rst_stable", {31'd0, held[2]}, 32'd1);
    applyStimulus(2);
    doTick();
    checkOutput("hold_rst_pulse", {31'd0, throw}, 32'd1);
    applyStimulus(5);
    doTick();
    applyStimulus(1);
    checkOutput("hold_rst_count", pcThrow, 1);
    throw_raw = 1'b0;
    applyStimulus(10);

    // Press coincident with tick while pending already set
    $display("[TB] coincident press and tick");
    clearCounts();
    throw_raw = 1'b1;
    applyStimulus(8);
    throw_raw = 1'b0;
    applyStimulus(8);
    throw_raw = 1'b1;
    applyStimulus(6);
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
    checkOutput("coinc_pulse", {31'd0, throw}, 32'd1);
    applyStimulus(1);
    checkOutput("coinc_width", {31'd0, throw}, 32'd0);
    applyStimulus(3);
    doTick();
    checkOutput("coinc_pending_clear", {31'd0, throw}, 32'd0);
    applyStimulus(1);
    checkOutput("coinc_count", pcThrow, 1);
    throw_raw = 1'b0;
    applyStimulus(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
